alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue stage between decode and the ALU in the RISC-V pipeline. Decodes the main-decoder `ALUOp` plus `funct3`/`funct7[5]` into the ALU's 4-bit `Operation` code, then carries operation, operands and destination register across the ID/EX boundary. A two-entry skid buffer with a valid/ready handshake provides full throughput under back-pressure, and a synchronous flush supports branch redirect.

## Interface
- `DATA_WIDTH`, 32, operand width.
- `OPCODE_LENGTH`, 4, ALU operation code width.
- `REG_ADDR_W`, 5, destination register index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept; registered, equals NOT skid-entry-full.
- `ALUOp`  in  2  main-decoder class: 00 mem, 01 branch, 10 R-type, 11 I-type.
- `Funct3`  in  3  instruction funct3.
- `Funct7b5`  in  1  instruction bit 30.
- `SrcA_in`, `SrcB_in`  in  DATA_WIDTH  operands.
- `Rd_in`  in  REG_ADDR_W  destination register.
- `flush`  in  1  synchronous kill of all held entries.
- `out_valid`  out  1  head entry valid toward ALU.
- `out_ready`  in  1  execute stage consumes head.
- `Operation`  out  OPCODE_LENGTH  decoded ALU code.
- `SrcA`, `SrcB`  out  DATA_WIDTH  registered operands.
- `Rd`  out  REG_ADDR_W  registered destination.
- `Illegal`  out  1  head entry has no legal decode.

## Operation
- Decode (combinational, on input side):
  - ALUOp 00 → ADD 4'b0010.
  - ALUOp 01: funct3 000/001 → EQ 4'b1000; else illegal.
  - ALUOp 10: funct3 000 with Funct7b5=0 → ADD, with 1 → SUB 4'b0110; 111 → AND 4'b0000; 110 → OR 4'b0001; else illegal.
  - ALUOp 11: 000 → ADD (Funct7b5 ignored); 111 → AND; 110 → OR; else illegal.
  - Illegal → `Operation`=4'b1111, `Illegal`=1; the entry still flows so the trap logic sees it.
- Storage: head register (drives outputs) plus one skid register. Accept on `in_valid && in_ready`; consume on `out_valid && out_ready`.
- Entry moves per cycle:
  - head empty: accepted entry goes to head.
  - head consumed, skid empty: accepted entry goes to head.
  - head full, not consumed, skid empty: accepted entry goes to skid.
  - skid full and head consumed: skid moves to head (no accept possible, `in_ready`=0).
- Order is strictly FIFO; no entry is dropped or duplicated.
- `flush`=1: at next edge head and skid become invalid; any entry accepted that same cycle is discarded; `in_ready`=1 the following cycle.

## Timing
- Reset (async assert, sync-safe deassert): `out_valid`=0, `Operation`=0, `SrcA`=`SrcB`=0, `Rd`=0, `Illegal`=0, skid empty, so `in_ready`=1.
- Latency: accept at edge N → `out_valid`=1 with that entry after edge N.
- Throughput: one entry per cycle while `out_ready`=1.
- `in_ready` depends only on state, never combinationally on `out_ready` or `in_valid`.
- Payload outputs hold stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-transfer: all entries lost, outputs return to reset values immediately.

## Configuration
- `ALU_ISSUE_PERF_EN` defined: adds outputs `issue_count` and `stall_count` (32 bits each, reset 0, wrap at 2^32). `issue_count` increments on every consume; `stall_count` increments each cycle with `out_valid`=1 and `out_ready`=0. Neither counter changes on flush.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, then ALUOp=10, Funct3=000, Funct7b5=1, SrcA=7, SrcB=3, Rd=5, `out_ready`=1 → one cycle later `out_valid`=1, `Operation`=4'b0110, `SrcA`=7, `SrcB`=3, `Rd`=5, `Illegal`=0.
- Decode sweep: ALUOp 00 → 0010; 01/001 → 1000; 10/111 → 0000; 11/110 → 0001; 10/010 → 1111 with `Illegal`=1.
- Back-pressure: `out_ready`=0, push A,B → `in_ready`=0 after B; raise `out_ready` → A then B on consecutive cycles, then `in_ready`=1.
- Streaming: 8 back-to-back entries with `out_ready`=1 → 8 consecutive outputs in order, `in_ready` never drops.
- Flush with both entries full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1; the flush-cycle input never appears.
- With `ALU_ISSUE_PERF_EN`: 3 stall cycles, then 4 consumes → `stall_count`=3, `issue_count`=4; `rst_n` low mid-stream → both 0 and `out_valid`=0 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Registered ID/EX issue stage in front of the ALU. Decodes the main-decoder
// ALUOp class together with funct3 / funct7[5] into the 4-bit ALU Operation
// code, then holds operation, operands and destination register in a
// two-entry skid buffer (head + skid) behind a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   decode-side handshake; in_ready = !skid_full (state only)
//   ALUOp, Funct3,      instruction class and function fields to decode
//   Funct7b5
//   SrcA_in, SrcB_in,   operands and destination register from decode
//   Rd_in
//   flush               synchronous kill of every held entry
//   out_valid/out_ready execute-side handshake on the head entry
//   Operation, SrcA,    registered head payload
//   SrcB, Rd, Illegal
//   issue_count,        performance counters, present only when the macro
//   stall_count         ALU_ISSUE_PERF_EN is defined
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic                     Funct7b5,
    input  logic [DATA_WIDTH-1:0]    SrcA_in,
    input  logic [DATA_WIDTH-1:0]    SrcB_in,
    input  logic [REG_ADDR_W-1:0]    Rd_in,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [REG_ADDR_W-1:0]    Rd,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]              issue_count,
    output logic [31:0]              stall_count,
`endif
    output logic                     Illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

    // Entry layout: {operation, srcA, srcB, rd, illegal}
    localparam int PW = OPCODE_LENGTH + 2 * DATA_WIDTH + REG_ADDR_W + 1;

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_ill;
    logic [PW-1:0]            in_pl;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          head_v_q, head_v_d;
    logic          skid_v_q, skid_v_d;

    logic accept;
    logic consume;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_op  = OP_ILL;
        dec_ill = 1'b1;
        unique case (ALUOp)
            2'b00: begin
                dec_op  = OP_ADD;
                dec_ill = 1'b0;
            end
            2'b01: begin
                if (Funct3 == 3'b000 || Funct3 == 3'b001) begin
                    dec_op  = OP_EQ;
                    dec_ill = 1'b0;
                end
            end
            2'b10: begin
                unique case (Funct3)
                    3'b000: begin
                        dec_op  = Funct7b5 ? OP_SUB : OP_ADD;
                        dec_ill = 1'b0;
                    end
                    3'b111: begin
                        dec_op  = OP_AND;
                        dec_ill = 1'b0;
                    end
                    3'b110: begin
                        dec_op  = OP_OR;
                        dec_ill = 1'b0;
                    end
                    default: ;
                endcase
            end
            2'b11: begin
                // Immediate forms have no SUB; bit 30 is part of the immediate.
                unique case (Funct3)
                    3'b000: begin
                        dec_op  = OP_ADD;
                        dec_ill = 1'b0;
                    end
                    3'b111: begin
                        dec_op  = OP_AND;
                        dec_ill = 1'b0;
                    end
                    3'b110: begin
                        dec_op  = OP_OR;
                        dec_ill = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign in_pl = {dec_op, SrcA_in, SrcB_in, Rd_in, dec_ill};

    // ------------------------------------------------------------------
    // Handshake and skid buffer
    // ------------------------------------------------------------------
    // in_ready comes straight from the skid valid flop, so it never depends
    // combinationally on out_ready or in_valid.
    assign in_ready  = ~skid_v_q;
    assign out_valid = head_v_q;
    assign accept    = in_valid & in_ready;
    assign consume   = head_v_q & out_ready;

    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            // Skid full implies in_ready=0: only a drain into head can happen.
            if (consume) begin
                head_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (!head_v_q || consume) begin
            head_v_d = accept;
            if (accept) begin
                head_d = in_pl;
            end
        end else if (accept) begin
            skid_d   = in_pl;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            skid_q   <= skid_d;
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign {Operation, SrcA, SrcB, Rd, Illegal} = head_q;

`ifdef ALU_ISSUE_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (consume) begin
            issue_cnt_d = issue_cnt_q + 32'd1;
        end
        if (head_v_q && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_count = issue_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic        Funct7b5;
    logic [31:0] SrcA_in;
    logic [31:0] SrcB_in;
    logic [4:0]  Rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [4:0]  Rd;
    logic        Illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issue_count;
    logic [31:0] stall_count;
    int unsigned issue_m;
    int unsigned stall_m;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(
        .DATA_WIDTH   (32),
        .OPCODE_LENGTH(4),
        .REG_ADDR_W   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUOp      (ALUOp),
        .Funct3     (Funct3),
        .Funct7b5   (Funct7b5),
        .SrcA_in    (SrcA_in),
        .SrcB_in    (SrcB_in),
        .Rd_in      (Rd_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Operation  (Operation),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Rd         (Rd),
`ifdef ALU_ISSUE_PERF_EN
        .issue_count(issue_count),
        .stall_count(stall_count),
`endif
        .Illegal    (Illegal)
    );

    // Reference model: a FIFO of capacity two holding decoded entries.
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } ent_t;

    ent_t mq[$];

    // Returns {illegal, operation} from the decode table.
    function automatic logic [4:0] exp_decode(logic [1:0] cls, logic [2:0] f3, logic f7);
        logic [4:0] r;
        r = 5'b1_1111;
        if (cls == 2'b00) r = 5'b0_0010;
        else if (cls == 2'b01) begin
            if (f3 <= 3'd1) r = 5'b0_1000;
        end else begin
            if (f3 == 3'd0)      r = (cls == 2'b10 && f7) ? 5'b0_0110 : 5'b0_0010;
            else if (f3 == 3'd7) r = 5'b0_0000;
            else if (f3 == 3'd6) r = 5'b0_0001;
        end
        return r;
    endfunction

    task automatic drive(logic iv, logic [1:0] cls, logic [2:0] f3, logic f7,
                         logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                         logic ordy, logic fl);
        in_valid  = iv;
        ALUOp     = cls;
        Funct3    = f3;
        Funct7b5  = f7;
        SrcA_in   = a;
        SrcB_in   = b;
        Rd_in     = rd;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Advance one clock; model updates from the inputs held across the edge.
    task automatic tick();
        logic       acc;
        logic       cons;
        logic [4:0] d;
        ent_t       e;
        acc  = in_valid && (mq.size() < 2);
        cons = (mq.size() > 0) && out_ready;
        d    = exp_decode(ALUOp, Funct3, Funct7b5);
        e.op  = d[3:0];
        e.ill = d[4];
        e.a   = SrcA_in;
        e.b   = SrcB_in;
        e.rd  = Rd_in;
`ifdef ALU_ISSUE_PERF_EN
        if (cons) issue_m++;
        if ((mq.size() > 0) && !out_ready) stall_m++;
`endif
        @(posedge clk);
        #1;
        if (flush) mq.delete();
        else begin
            if (cons) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
    endtask

    task automatic apply_reset();
        drive(1'b0, 2'b00, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        mq.delete();
`ifdef ALU_ISSUE_PERF_EN
        issue_m = 0;
        stall_m = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b00, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #13;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if ({Operation, SrcA, SrcB, Rd, Illegal} !== '0) begin
            fails++;
            $display("FAIL reset_payload: op=%h a=%h b=%h rd=%h ill=%b want all 0",
                     Operation, SrcA, SrcB, Rd, Illegal);
        end
`ifdef ALU_ISSUE_PERF_EN
        checks++;
        if (issue_count !== 32'd0 || stall_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_perf: issue=%0d stall=%0d want 0/0", issue_count, stall_count);
        end
`endif
        apply_reset();
    endtask

    task automatic test_first_sub();
        drive(1'b1, 2'b10, 3'b000, 1'b1, 32'd7, 32'd3, 5'd5, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || Operation !== 4'b0110 || SrcA !== 32'd7 ||
            SrcB !== 32'd3 || Rd !== 5'd5 || Illegal !== 1'b0) begin
            fails++;
            $display("FAIL first_sub: v=%b op=%b a=%0d b=%0d rd=%0d ill=%b want 1/0110/7/3/5/0",
                     out_valid, Operation, SrcA, SrcB, Rd, Illegal);
        end
        tick();
    endtask

    task automatic test_decode_sweep();
        logic [1:0] cls [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
        logic [2:0] f3  [5] = '{3'b101, 3'b001, 3'b111, 3'b110, 3'b010};
        logic [3:0] wop [5] = '{4'b0010, 4'b1000, 4'b0000, 4'b0001, 4'b1111};
        logic       will[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, cls[i], f3[i], 1'($urandom), $urandom, $urandom, 5'(i), 1'b1, 1'b0);
            tick();
            checks++;
            if (out_valid !== 1'b1 || Operation !== wop[i] || Illegal !== will[i]) begin
                fails++;
                $display("FAIL decode_%0d: v=%b op=%b ill=%b want 1/%b/%b",
                         i, out_valid, Operation, Illegal, wop[i], will[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 2'b00, 3'd0, 1'b0, 32'hA, 32'hA0, 5'd10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b11, 3'd7, 1'b0, 32'hB, 32'hB0, 5'd11, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || SrcA !== 32'hA) begin
            fails++;
            $display("FAIL bp_full: in_ready=%b v=%b a=%h want 0/1/a", in_ready, out_valid, SrcA);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || SrcA !== 32'hA) begin
            fails++;
            $display("FAIL bp_hold: v=%b a=%h want 1/a", out_valid, SrcA);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || SrcA !== 32'hB || Operation !== 4'b0000 || Rd !== 5'd11) begin
            fails++;
            $display("FAIL bp_second: v=%b a=%h op=%b rd=%0d want 1/b/0000/11",
                     out_valid, SrcA, Operation, Rd);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_drained: v=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b10, 3'd6, 1'b0, 32'(100 + i), 32'(200 + i), 5'(i + 1), 1'b1, 1'b0);
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || SrcA !== 32'(100 + i) ||
                Rd !== 5'(i + 1)) begin
                fails++;
                $display("FAIL stream_%0d: rdy=%b v=%b a=%0d rd=%0d want 1/1/%0d/%0d",
                         i, in_ready, out_valid, SrcA, Rd, 100 + i, i + 1);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 2'b00, 3'd0, 1'b0, 32'h11, 32'd0, 5'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b00, 3'd0, 1'b0, 32'h22, 32'd0, 5'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b00, 3'd0, 1'b0, 32'h33, 32'd0, 5'd3, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_full: v=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        // Flush while the slot is open: the accepted input must still vanish.
        drive(1'b1, 2'b00, 3'd0, 1'b0, 32'h44, 32'd0, 5'd4, 1'b1, 1'b1);
        tick();
        drive(1'b0, 2'b00, 3'd0, 1'b0, 32'h0, 32'd0, 5'd0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_accept: v=%b a=%h want 0", out_valid, SrcA);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_after: v=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 1'($urandom),
                  $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
            tick();
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                fails++;
                $display("FAIL rand_hs cyc %0d: v=%b rdy=%b want %b/%b",
                         c, out_valid, in_ready, mq.size() > 0, mq.size() < 2);
            end
            if (mq.size() > 0) begin
                checks++;
                if (Operation !== mq[0].op || SrcA !== mq[0].a || SrcB !== mq[0].b ||
                    Rd !== mq[0].rd || Illegal !== mq[0].ill) begin
                    fails++;
                    $display("FAIL rand_data cyc %0d: op=%b a=%h b=%h rd=%0d ill=%b want %b/%h/%h/%0d/%b",
                             c, Operation, SrcA, SrcB, Rd, Illegal,
                             mq[0].op, mq[0].a, mq[0].b, mq[0].rd, mq[0].ill);
                end
            end
`ifdef ALU_ISSUE_PERF_EN
            checks++;
            if (issue_count !== issue_m || stall_count !== stall_m) begin
                fails++;
                $display("FAIL rand_perf cyc %0d: issue=%0d stall=%0d want %0d/%0d",
                         c, issue_count, stall_count, issue_m, stall_m);
            end
`endif
        end
        drive(1'b0, 2'b00, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        tick();
        tick();
    endtask

`ifdef ALU_ISSUE_PERF_EN
    task automatic test_perf();
        apply_reset();
        drive(1'b1, 2'b00, 3'd0, 1'b0, 32'd1, 32'd0, 5'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b00, 3'd0, 1'b0, 32'd2, 32'd0, 5'd2, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        drive(1'b1, 2'b00, 3'd0, 1'b0, 32'd3, 32'd0, 5'd3, 1'b1, 1'b0);
        tick();
        tick();
        SrcA_in = 32'd4;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (stall_count !== 32'd3 || issue_count !== 32'd4) begin
            fails++;
            $display("FAIL perf_counts: stall=%0d issue=%0d want 3/4", stall_count, issue_count);
        end
    endtask
`endif

    task automatic test_reset_mid();
        drive(1'b1, 2'b01, 3'd0, 1'b0, 32'h55, 32'h66, 5'd7, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Operation !== 4'd0 ||
            SrcA !== 32'd0 || Rd !== 5'd0) begin
            fails++;
            $display("FAIL reset_mid: v=%b rdy=%b op=%b a=%h rd=%0d want 0/1/0/0/0",
                     out_valid, in_ready, Operation, SrcA, Rd);
        end
`ifdef ALU_ISSUE_PERF_EN
        checks++;
        if (issue_count !== 32'd0 || stall_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_perf: issue=%0d stall=%0d want 0/0", issue_count, stall_count);
        end
`endif
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_first_sub();
        test_decode_sweep();
        test_back_pressure();
        test_streaming();
        test_flush();
        test_random();
`ifdef ALU_ISSUE_PERF_EN
        test_perf();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
